// File: rtl/pps_rx_qualifier.sv
// PPS receive qualifier: synchronises pps_i, rejects short pulses, timestamps accepted edges,
// tracks period/lock/LOS and queues event records. Optional macro: PPS_RX_LAT_COMP_EN.
`ifndef FNS_W
`define FNS_W 16
`endif

module pps_rx_qualifier #(
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_WIDTH_CYC = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int LOCK_CNT      = 3,
    parameter int LOS_SEC       = 2
) (
    input  logic        rtc_clk,
    input  logic        rtc_rst,
    input  logic        enable_i,
    input  logic [79:0] rtc_std_i,
    input  logic [15:0] rtc_fns_i,
    input  logic [31:0] tick_inc_i,
    input  logic [31:0] tol_ns_i,
    input  logic        pps_i,
    output logic        evt_valid_o,
    input  logic        evt_ready_i,
    output logic [79:0] evt_std_o,
    output logic [15:0] evt_fns_o,
    output logic [31:0] evt_phase_o,
    output logic [3:0]  evt_flags_o,
    output logic        lock_o,
    output logic        los_o,
    output logic [15:0] glitch_cnt_o,
    output logic [15:0] ovf_cnt_o
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_LOW  = 2'd1;
    localparam logic [1:0]  S_QUAL = 2'd2;
    localparam logic [1:0]  S_HIGH = 2'd3;
    localparam int          HW = $clog2(MIN_WIDTH_CYC + 1);
    localparam int          OW = $clog2(LOCK_CNT + 1);
    localparam int          AW = $clog2(FIFO_DEPTH);
    localparam int          EW = 132;
    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_d_r;
    logic                   sync_s, rise_s;
    logic [1:0]             state_r, state_n;
    logic [HW-1:0]          hcnt_r;
    logic                   capture_s, accept_s, glitch_s;
    logic [47:0]            cap_sec_s, cand_sec_r, last_sec_r, sdiff_s;
    logic [31:0]            cap_ns_s, cand_ns_r, last_ns_r, phase_s;
    logic [15:0]            cap_fns_s, cand_fns_r;
    logic                   last_valid_r, first_r, first_n, los_n, lock_n, per_ok_s;
    logic [33:0]            period_s, dev_s;
    logic [OW-1:0]          okcnt_r, okcnt_n;
    logic [7:0]             secs_r, secs_n;
    logic                   sec_lsb_r, toggle_s;
    logic [3:0]             flags_s;
    logic [EW-1:0]          fifo_mem_r [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_r, rd_ptr_r;
    logic                   full_s, pop_s, push_ok_s, drop_s, ovf_pend_r;

    assign sync_s = sync_r[SYNC_STAGES-1];
    assign rise_s = sync_s & ~sync_d_r;

    // Synchroniser chain plus delayed copy for edge detection
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            sync_r   <= '0;
            sync_d_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], pps_i};
            sync_d_r <= sync_s;
        end
    end

`ifdef PPS_RX_LAT_COMP_EN
    logic [39:0] comp_s;
    logic [31:0] comp_ns_s;
    logic [15:0] comp_fns_s;
    logic [16:0] fns_diff_s;
    logic [32:0] ns_diff_s;

    // Back out synchroniser latency from the raw RTC, borrowing fns -> ns -> seconds
    always_comb begin
        comp_s     = 40'(SYNC_STAGES + 1) * {8'd0, tick_inc_i};
        comp_ns_s  = 32'(comp_s >> `FNS_W);
        comp_fns_s = comp_s[`FNS_W-1 -: 16];
        fns_diff_s = {1'b0, rtc_fns_i} - {1'b0, comp_fns_s};
        ns_diff_s  = {1'b0, rtc_std_i[31:0]} - {1'b0, comp_ns_s} - {32'd0, fns_diff_s[16]};
        cap_fns_s  = fns_diff_s[15:0];
        if (ns_diff_s[32]) begin
            cap_ns_s  = ns_diff_s[31:0] + NS_PER_SEC;
            cap_sec_s = rtc_std_i[79:32] - 48'd1;
        end else begin
            cap_ns_s  = ns_diff_s[31:0];
            cap_sec_s = rtc_std_i[79:32];
        end
    end
`else
    logic unused_tick_s;
    assign unused_tick_s = ^tick_inc_i;

    // Raw RTC value at the rise cycle
    always_comb begin
        cap_sec_s = rtc_std_i[79:32];
        cap_ns_s  = rtc_std_i[31:0];
        cap_fns_s = rtc_fns_i;
    end
`endif

    // Edge qualification FSM; the rise cycle counts as the first high cycle
    always_comb begin
        state_n   = state_r;
        capture_s = 1'b0;
        accept_s  = 1'b0;
        glitch_s  = 1'b0;
        if (!enable_i) begin
            state_n = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: if (!sync_s) state_n = S_LOW; else state_n = S_IDLE;
                S_LOW: begin
                    if (rise_s) begin
                        capture_s = 1'b1;
                        state_n   = S_QUAL;
                    end else begin
                        state_n = S_LOW;
                    end
                end
                S_QUAL: begin
                    if ((32'(hcnt_r) >= MIN_WIDTH_CYC) ||
                        (sync_s && (32'(hcnt_r) + 32'd1 >= MIN_WIDTH_CYC))) begin
                        accept_s = 1'b1;
                        state_n  = S_HIGH;
                    end else if (!sync_s) begin
                        glitch_s = 1'b1;
                        state_n  = S_LOW;
                    end else begin
                        state_n = S_QUAL;
                    end
                end
                S_HIGH: if (!sync_s) state_n = S_LOW; else state_n = S_HIGH;
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Period, phase and flag computation for the candidate edge
    always_comb begin
        sdiff_s  = cand_sec_r - last_sec_r;
        period_s = 34'(sdiff_s[1:0]) * 34'd1_000_000_000 + 34'(cand_ns_r) - 34'(last_ns_r);
        if (period_s >= 34'd1_000_000_000) dev_s = period_s - 34'd1_000_000_000;
        else dev_s = 34'd1_000_000_000 - period_s;
        per_ok_s = last_valid_r && !first_r && (sdiff_s <= 48'd2) && (dev_s <= 34'(tol_ns_i));
        if (cand_ns_r < 32'd500_000_000) phase_s = cand_ns_r;
        else phase_s = cand_ns_r - NS_PER_SEC;
        flags_s  = {lock_o, ovf_pend_r, first_r, per_ok_s};
    end

    // Lock / LOS / first-edge bookkeeping; an accepted edge always clears LOS
    always_comb begin
        toggle_s = rtc_std_i[32] ^ sec_lsb_r;
        secs_n   = secs_r;
        okcnt_n  = okcnt_r;
        first_n  = first_r;
        los_n    = los_o;
        if (!enable_i) begin
            secs_n  = 8'd0;
            okcnt_n = '0;
            first_n = 1'b1;
            los_n   = 1'b0;
        end else if (accept_s) begin
            secs_n  = 8'd0;
            first_n = 1'b0;
            los_n   = 1'b0;
            if (!per_ok_s) okcnt_n = '0;
            else if (32'(okcnt_r) == LOCK_CNT) okcnt_n = okcnt_r;
            else okcnt_n = okcnt_r + OW'(1);
        end else begin
            if (toggle_s && (secs_r != 8'hFF)) secs_n = secs_r + 8'd1;
            else secs_n = secs_r;
            if (32'(secs_n) > LOS_SEC) begin
                los_n   = 1'b1;
                okcnt_n = '0;
                first_n = 1'b1;
            end else begin
                los_n = los_o;
            end
        end
        lock_n = (32'(okcnt_n) == LOCK_CNT) && !los_n;
    end

    // Control state, candidate/last timestamps and status outputs
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            state_r      <= S_IDLE;
            hcnt_r       <= '0;
            cand_sec_r   <= 48'd0;
            cand_ns_r    <= 32'd0;
            cand_fns_r   <= 16'd0;
            last_sec_r   <= 48'd0;
            last_ns_r    <= 32'd0;
            last_valid_r <= 1'b0;
            first_r      <= 1'b1;
            okcnt_r      <= '0;
            secs_r       <= 8'd0;
            sec_lsb_r    <= 1'b0;
            lock_o       <= 1'b0;
            los_o        <= 1'b0;
            glitch_cnt_o <= 16'd0;
        end else begin
            state_r   <= state_n;
            first_r   <= first_n;
            okcnt_r   <= okcnt_n;
            secs_r    <= secs_n;
            sec_lsb_r <= rtc_std_i[32];
            lock_o    <= lock_n;
            los_o     <= los_n;
            if (capture_s) begin
                hcnt_r     <= HW'(1);
                cand_sec_r <= cap_sec_s;
                cand_ns_r  <= cap_ns_s;
                cand_fns_r <= cap_fns_s;
            end else if (state_r == S_QUAL && sync_s) begin
                hcnt_r <= hcnt_r + HW'(1);
            end else begin
                hcnt_r <= hcnt_r;
            end
            if (accept_s) begin
                last_sec_r   <= cand_sec_r;
                last_ns_r    <= cand_ns_r;
                last_valid_r <= 1'b1;
            end
            if (glitch_s && glitch_cnt_o != 16'hFFFF) glitch_cnt_o <= glitch_cnt_o + 16'd1;
        end
    end

    assign pop_s     = evt_valid_o & evt_ready_i;
    assign full_s    = (wr_ptr_r - rd_ptr_r) == DEPTH_C;
    assign push_ok_s = accept_s & (~full_s | pop_s);
    assign drop_s    = accept_s & full_s & ~pop_s;

    // Event FIFO storage, pointers and overflow tracking
    always_ff @(posedge rtc_clk) begin
        if (rtc_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            ovf_pend_r <= 1'b0;
            ovf_cnt_o  <= 16'd0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r[AW-1:0]] <= {cand_sec_r, cand_ns_r, cand_fns_r, phase_s, flags_s};
                wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
            if (drop_s) begin
                ovf_pend_r <= 1'b1;
                if (ovf_cnt_o != 16'hFFFF) ovf_cnt_o <= ovf_cnt_o + 16'd1;
            end else if (push_ok_s) begin
                ovf_pend_r <= 1'b0;
            end
        end
    end

    assign evt_valid_o = (wr_ptr_r != rd_ptr_r);
    assign evt_std_o   = fifo_mem_r[rd_ptr_r[AW-1:0]][131:52];
    assign evt_fns_o   = fifo_mem_r[rd_ptr_r[AW-1:0]][51:36];
    assign evt_phase_o = fifo_mem_r[rd_ptr_r[AW-1:0]][35:4];
    assign evt_flags_o = fifo_mem_r[rd_ptr_r[AW-1:0]][3:0];

endmodule
